// File: rtl/i2c_slave_reg_sequencer_if.sv
// Bus bundle between the I2C slave byte core / local host and the register sequencer.
// The slave modport is the sequencer side; the master modport is the driving side.
interface i2c_slave_reg_sequencer_if;
   logic [6:0] address;
   logic       frame;
   logic       received;
   logic [7:0] datareceive;
   logic       sended;
   logic [7:0] datasend;
   logic [3:0] host_addr;
   logic       host_we;
   logic [7:0] host_wdata;
   logic       host_ack;
   logic [7:0] host_rdata;
   logic       updated;
   logic [3:0] updated_addr;

   modport slave (
      input  frame, received, datareceive, sended, host_addr, host_we, host_wdata,
      output address, datasend, host_ack, host_rdata, updated, updated_addr
   );

   modport master (
      output frame, received, datareceive, sended, host_addr, host_we, host_wdata,
      input  address, datasend, host_ack, host_rdata, updated, updated_addr
   );
endinterface

// File: rtl/i2c_slave_reg_sequencer.sv
// Pointer-addressed 16 x 8 register bank behind an I2C slave byte core, shared with a host port.
// Optional macro I2C_REGS_AUTOINC_EN: data bytes advance the pointer (wrap 15 -> 0).
module i2c_slave_reg_sequencer #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter logic [7:0] RESET_VAL  = 8'h00
) (
   input  logic                        clk,
   input  logic                        reset,
   i2c_slave_reg_sequencer_if.slave    bus
);

   typedef enum logic [1:0] {S_IDLE, S_PTR, S_DATA} state_t;

   state_t     r_state;
   logic [3:0] r_ptr;
   logic       r_frame_q;
   logic [7:0] r_regs [16];
   logic [7:0] r_datasend;
   logic [7:0] r_host_rdata;
   logic       r_updated;
   logic [3:0] r_updated_addr;

   logic       w_frame_rise;
   logic       w_i2c_we;
   logic       w_host_ack;

   function automatic logic [3:0] f_advance(input logic [3:0] ptr);
`ifdef I2C_REGS_AUTOINC_EN
      return ptr + 4'd1;
`else
      return ptr;
`endif
   endfunction

   assign w_frame_rise = bus.frame & ~r_frame_q;
   assign w_i2c_we     = bus.frame & bus.received & (r_state == S_DATA);
   assign w_host_ack   = bus.host_we & ~w_i2c_we;

   assign bus.address      = SLAVE_ADDR;
   assign bus.datasend     = r_datasend;
   assign bus.host_ack     = w_host_ack;
   assign bus.host_rdata   = r_host_rdata;
   assign bus.updated      = r_updated;
   assign bus.updated_addr = r_updated_addr;

   // r_frame_q resets high so a frame already active across reset is not seen as a new rise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_ptr          <= 4'd0;
         r_frame_q      <= 1'b1;
         r_updated      <= 1'b0;
         r_updated_addr <= 4'd0;
      end else begin
         r_frame_q <= bus.frame;
         r_updated <= 1'b0;
         if (!bus.frame) begin
            r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_frame_rise) begin
                     if (bus.received) begin
                        r_ptr   <= bus.datareceive[3:0];
                        r_state <= S_DATA;
                     end else begin
                        r_state <= S_PTR;
                     end
                  end
               end
               S_PTR: begin
                  if (bus.received) begin
                     r_ptr   <= bus.datareceive[3:0];
                     r_state <= S_DATA;
                  end else if (bus.sended) begin
                     r_ptr   <= f_advance(r_ptr);
                     r_state <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (bus.received) begin
                     r_updated      <= 1'b1;
                     r_updated_addr <= r_ptr;
                     r_ptr          <= f_advance(r_ptr);
                  end else if (bus.sended) begin
                     r_ptr <= f_advance(r_ptr);
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // I2C writes win; the host write lands only in cycles where host_ack is high
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) r_regs[i] <= RESET_VAL;
      end else if (w_i2c_we) begin
         r_regs[r_ptr] <= bus.datareceive;
      end else if (w_host_ack) begin
         r_regs[bus.host_addr] <= bus.host_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_datasend   <= RESET_VAL;
         r_host_rdata <= RESET_VAL;
      end else begin
         r_datasend   <= r_regs[r_ptr];
         r_host_rdata <= r_regs[bus.host_addr];
      end
   end

endmodule

// File: tb/tb_i2c_slave_reg_sequencer.sv
// Randomized and directed bench for i2c_slave_reg_sequencer against a byte-level register model.
// Honours I2C_REGS_AUTOINC_EN the same way the design does.
module tb_i2c_slave_reg_sequencer;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   logic [7:0] m_regs [16];
   logic [3:0] m_ptr;
   bit         m_first;

   i2c_slave_reg_sequencer_if bus ();

   i2c_slave_reg_sequencer #(
      .SLAVE_ADDR (7'h50),
      .RESET_VAL  (8'h00)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] m_adv(input logic [3:0] p);
`ifdef I2C_REGS_AUTOINC_EN
      return (p == 4'd15) ? 4'd0 : p + 4'd1;
`else
      return p;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_ptr = 4'd0;
      m_first = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame_start();
      bus.frame = 1'b1;
      m_first = 1'b1;
      tick();
   endtask

   task automatic frame_stop();
      bus.frame = 1'b0;
      tick();
      tick();
   endtask

   // One master-written byte; also_sent drives sended in the same cycle
   task automatic wr_byte(input logic [7:0] b, input bit also_sent);
      bus.received = 1'b1;
      bus.sended = also_sent;
      bus.datareceive = b;
      tick();
      bus.received = 1'b0;
      bus.sended = 1'b0;
      if (m_first) begin
         chk("upd_on_ptr_byte", bus.updated, 0);
         m_ptr = b[3:0];
         m_first = 1'b0;
      end else begin
         chk("upd_pulse", bus.updated, 1);
         chk("upd_addr", bus.updated_addr, m_ptr);
         m_regs[m_ptr] = b;
         m_ptr = m_adv(m_ptr);
      end
      tick();
   endtask

   task automatic rd_byte();
      chk("datasend", bus.datasend, m_regs[m_ptr]);
      bus.sended = 1'b1;
      tick();
      bus.sended = 1'b0;
      chk("upd_on_read", bus.updated, 0);
      m_ptr = m_adv(m_ptr);
      m_first = 1'b0;
      tick();
   endtask

   task automatic host_write(input logic [3:0] a, input logic [7:0] d);
      bus.host_addr = a;
      bus.host_wdata = d;
      bus.host_we = 1'b1;
      #1;
      chk("host_ack", bus.host_ack, 1);
      tick();
      bus.host_we = 1'b0;
      m_regs[a] = d;
      tick();
      chk("host_rd_after_wr", bus.host_rdata, d);
      chk("datasend_track", bus.datasend, m_regs[m_ptr]);
   endtask

   task automatic host_read(input logic [3:0] a);
      bus.host_addr = a;
      tick();
      chk("host_rd", bus.host_rdata, m_regs[a]);
   endtask

   initial begin
      total = 0;
      bad = 0;
      reset = 1'b1;
      bus.frame = 1'b0;
      bus.received = 1'b0;
      bus.sended = 1'b0;
      bus.datareceive = 8'h00;
      bus.host_addr = 4'd0;
      bus.host_we = 1'b0;
      bus.host_wdata = 8'h00;
      model_reset();
      tick();
      tick();
      chk("rst_datasend", bus.datasend, 8'h00);
      chk("rst_host_rdata", bus.host_rdata, 8'h00);
      chk("rst_host_ack", bus.host_ack, 0);
      chk("rst_updated", bus.updated, 0);
      chk("rst_updated_addr", bus.updated_addr, 0);
      chk("address", bus.address, 7'h50);
      reset = 1'b0;
      tick();

      // write burst 03 A5 5A
      frame_start();
      wr_byte(8'h03, 1'b0);
      wr_byte(8'hA5, 1'b0);
      wr_byte(8'h5A, 1'b0);
      frame_stop();
      host_read(4'd3);
      host_read(4'd4);
`ifdef I2C_REGS_AUTOINC_EN
      chk("burst_r3_lit", m_regs[3], 8'hA5);
      bus.host_addr = 4'd4;
      tick();
      chk("burst_r4_lit", bus.host_rdata, 8'h5A);
`endif

      // pointer retained across frames
      frame_start();
      wr_byte(8'h03, 1'b0);
      frame_stop();
      frame_start();
      rd_byte();
      rd_byte();
      frame_stop();

`ifdef I2C_REGS_AUTOINC_EN
      frame_start();
      wr_byte(8'hFF, 1'b0);
      wr_byte(8'h11, 1'b0);
      wr_byte(8'h22, 1'b0);
      frame_stop();
      bus.host_addr = 4'd15;
      tick();
      chk("wrap_r15", bus.host_rdata, 8'h11);
      bus.host_addr = 4'd0;
      tick();
      chk("wrap_r0", bus.host_rdata, 8'h22);
`else
      frame_start();
      wr_byte(8'h02, 1'b0);
      wr_byte(8'h10, 1'b0);
      wr_byte(8'h20, 1'b0);
      rd_byte();
      chk("noinc_rd2", bus.datasend, 8'h20);
      rd_byte();
      frame_stop();
      host_read(4'd2);
      host_read(4'd3);
`endif

      // pointer byte arriving in the same cycle as the frame rise
      bus.frame = 1'b1;
      bus.received = 1'b1;
      bus.datareceive = 8'h6A;
      tick();
      bus.received = 1'b0;
      m_ptr = 4'hA;
      m_first = 1'b0;
      chk("rise_ptr_no_upd", bus.updated, 0);
      tick();
      wr_byte(8'hE1, 1'b0);
      // received and sended together: one write, one advance
      wr_byte(8'h4B, 1'b1);
      rd_byte();
      frame_stop();

      // arbitration: host write to 7 collides with an I2C write to 7
      frame_start();
      wr_byte(8'h07, 1'b0);
      bus.received = 1'b1;
      bus.datareceive = 8'h3C;
      bus.host_we = 1'b1;
      bus.host_addr = 4'd7;
      bus.host_wdata = 8'hC3;
      #1;
      chk("ack_collide", bus.host_ack, 0);
      tick();
      bus.received = 1'b0;
      #1;
      chk("ack_next", bus.host_ack, 1);
      chk("arb_upd", bus.updated, 1);
      chk("arb_upd_addr", bus.updated_addr, 4'd7);
      m_regs[7] = 8'h3C;
      m_ptr = m_adv(m_ptr);
      tick();
      bus.host_we = 1'b0;
      m_regs[7] = 8'hC3;
      tick();
      chk("arb_r7", bus.host_rdata, 8'hC3);
      frame_stop();

      // randomized frames
      for (int f = 0; f < 40; f++) begin
         int kind;
         int n;
         kind = $urandom_range(0, 2);
         n = $urandom_range(1, 4);
         frame_start();
         if (kind != 1) wr_byte(8'($urandom), 1'b0);
         for (int k = 0; k < n; k++) begin
            if (kind == 0) wr_byte(8'($urandom), 1'b0);
            else rd_byte();
            if ($urandom_range(0, 3) == 0) host_write(4'($urandom), 8'($urandom));
         end
         frame_stop();
         if ($urandom_range(0, 1) == 1) host_write(4'($urandom), 8'($urandom));
         host_read(4'($urandom));
      end
      for (int i = 0; i < 16; i++) host_read(4'(i));

      // reset in the middle of a write burst
      frame_start();
      wr_byte(8'h05, 1'b0);
      wr_byte(8'hD7, 1'b0);
      bus.received = 1'b1;
      bus.datareceive = 8'hEE;
      bus.host_addr = 4'd5;
      reset = 1'b1;
      #1;
      chk("mid_rst_datasend", bus.datasend, 8'h00);
      chk("mid_rst_host_rdata", bus.host_rdata, 8'h00);
      chk("mid_rst_updated", bus.updated, 0);
      chk("mid_rst_upd_addr", bus.updated_addr, 0);
      chk("mid_rst_host_ack", bus.host_ack, 0);
      bus.received = 1'b0;
      tick();
      reset = 1'b0;
      model_reset();
      tick();
      // frame still high: this byte belongs to the abandoned frame and must be ignored
      bus.received = 1'b1;
      bus.datareceive = 8'h77;
      tick();
      bus.received = 1'b0;
      chk("post_rst_ignored", bus.updated, 0);
      tick();
      for (int i = 0; i < 16; i++) host_read(4'(i));
      chk("post_rst_datasend", bus.datasend, 8'h00);
      frame_stop();
      frame_start();
      wr_byte(8'h03, 1'b0);
      wr_byte(8'h99, 1'b0);
      frame_stop();
      host_read(4'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_slave_reg_sequencer.md
# i2c_slave_reg_sequencer

Register-file controller that sequences the I2C slave byte datapath. It turns the slave's raw byte-received and byte-sent pulses into pointer-addressed reads and writes of a 16 x 8 register bank. It also arbitrates that bank between the I2C side and a local host port. It sits between the I2C slave core and on-chip logic, replacing the fixed-data slave driver.

## Interface
Parameters:
- SLAVE_ADDR, 7'h50, 7-bit I2C address presented to the slave core.
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- clk  in  1  system clock (the divided clock when the board build uses it).
- reset  in  1  asynchronous, active-high reset.
- address  out  7  constant SLAVE_ADDR.
- frame  in  1  high while the slave core is addressed, from START/address match to STOP.
- received  in  1  one-cycle pulse; datareceive is valid.
- datareceive  in  8  byte written by the master.
- sended  in  1  one-cycle pulse; the master has clocked out the current datasend byte.
- datasend  out  8  byte for the next master read.
- host_addr  in  4  host register index.
- host_we  in  1  host write request.
- host_wdata  in  8  host write data.
- host_ack  out  1  host write accepted this cycle.
- host_rdata  out  8  registered read of regs[host_addr].
- updated  out  1  one-cycle pulse after an I2C write to a register.
- updated_addr  out  4  index written; valid with updated.

## Operation
Reset values:
- Every register is RESET_VAL.
- State is IDLE and the pointer is 0.
- datasend = RESET_VAL, host_rdata = RESET_VAL.
- host_ack = 0, updated = 0, updated_addr = 0.

State machine:
- IDLE: when frame rises, go to PTR.
- PTR: on received, set pointer = datareceive[3:0]; bits [7:4] are ignored. Go to DATA. On sended, apply the pointer advance rule and go to DATA; this is a read without a pointer write and uses the retained pointer.
- DATA: on received, write regs[pointer] = datareceive, pulse updated with updated_addr = old pointer, then apply the advance rule. On sended, apply the advance rule.
- Any state: frame low returns to IDLE next cycle. The pointer is retained across frames, so a write-pointer frame followed by a read frame reads from that pointer.

Pointer rules:
- The pointer is a 4-bit counter. Advancing it from 15 wraps to 0.
- If received and sended are both high in one cycle, received is processed and the pointer advances once only.
- A received pulse in the same cycle frame rises counts as the pointer byte.

Arbitration:
- An I2C write has priority. host_ack = host_we & ~(I2C write this cycle), for any addresses.
- The host must hold host_we, host_addr and host_wdata until host_ack is high.
- A host write executes only when host_ack is high.

Reset while a frame is active: all state is reinitialised immediately. The frame in progress is abandoned, and the FSM waits in IDLE for the next frame rising edge.

## Timing
- received at cycle N: the register is written at the end of N. updated is high in N+1. host_rdata shows the new value in N+2 if host_addr matches.
- Pointer change at the end of cycle N: datasend = regs[new pointer] at the end of N+1.
- The slave core has many SCL periods between bytes, so this latency is always met.
- Host write acked in N: host_rdata reflects it in N+2.
- host_rdata has 1-cycle latency from host_addr.
- datasend tracks host writes to regs[pointer] with 1-cycle latency.
- The frame falling edge is sampled; IDLE is reached 1 cycle later.

## Configuration
Macro I2C_REGS_AUTOINC_EN:
- Defined: the advance rule increments the pointer with wrap 15 to 0. Burst reads and writes walk through the bank.
- Undefined: the advance rule leaves the pointer unchanged. Every data byte in a burst reads or writes the same register, and only a pointer byte changes the pointer.

## Test plan
- Reset mid-frame: assert reset during a DATA write burst. Every output returns to its reset value, all registers read 8'h00, and after a new frame rises the FSM is in PTR.
- Write burst: frame rises, then received 8'h03, 8'hA5, 8'h5A. regs[3]=A5 and regs[4]=5A. updated pulses twice, with updated_addr 3 then 4.
- Wrap, AUTOINC_EN defined: pointer byte 8'hFF (upper bits masked, pointer 15), then write 8'h11 and 8'h22. Result: regs[15]=11, regs[0]=22.
- Pointer retained: frame with pointer 8'h03, frame low, then a new read frame. datasend=A5; after sended, datasend=5A within 2 cycles.
- Arbitration: host_we to address 7 with 8'hC3 in the same cycle as an I2C write of 8'h3C to regs[7]. host_ack=0 that cycle and 1 the next; regs[7] ends at C3.
- AUTOINC_EN undefined: pointer byte 8'h02, then write 8'h10 and 8'h20. regs[2]=20, regs[3] is unchanged, and two sended pulses both return 20.
